// File: rtl/fetch_pkg.sv
// Shared types and defaults for the instruction fetch sequencer.
package fetch_pkg;

   localparam int unsigned DEFAULT_MEM_SIZE = 1024;
   localparam logic [63:0] DEFAULT_RESET_PC = 64'h0;

   typedef enum logic {
      FETCH = 1'b0,
      FAULT = 1'b1
   } fetch_state_t;

   typedef struct packed {
      logic [63:0] pc;
      logic [31:0] instr;
   } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Circular buffer of fetched {pc, instr} entries with push/pop/flush.
module fetch_fifo
   import fetch_pkg::*;
#(
   parameter int unsigned BUF_DEPTH = 2
) (
   input  logic                             clk,
   input  logic                             reset_n,
   input  logic                             push,
   input  logic                             pop,
   input  logic                             flush,
   input  fetch_entry_t                     wr_data,
   output fetch_entry_t                     rd_data,
   output logic [$clog2(BUF_DEPTH+1)-1:0]   count,
   output logic                             full,
   output logic                             empty
);

   localparam int unsigned PTR_W = $clog2(BUF_DEPTH);
   localparam int unsigned CNT_W = $clog2(BUF_DEPTH + 1);

   fetch_entry_t           mem [BUF_DEPTH];
   logic [PTR_W-1:0]       rd_ptr;
   logic [PTR_W-1:0]       wr_ptr;
   logic                   do_pop;

   assign do_pop  = pop && !empty;
   assign full    = (count == CNT_W'(BUF_DEPTH));
   assign empty   = (count == '0);
   assign rd_data = mem[rd_ptr];

   // Pointers wrap naturally because BUF_DEPTH is a power of two.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (push)   wr_ptr <= wr_ptr + PTR_W'(1);
         if (do_pop) rd_ptr <= rd_ptr + PTR_W'(1);
         case ({push, do_pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (push && !flush) mem[wr_ptr] <= wr_data;
   end

endmodule

// File: rtl/fetch_unit.sv
// Fetch sequencer: owns the PC, drives the ROM address, buffers fetched
// instructions for decode, handles redirects and traps bad fetch addresses.
module fetch_unit
   import fetch_pkg::*;
#(
   parameter int unsigned MEM_SIZE  = DEFAULT_MEM_SIZE,
   parameter logic [63:0] RESET_PC  = DEFAULT_RESET_PC,
   parameter int unsigned BUF_DEPTH = 2
) (
   input  logic        clk,
   input  logic        reset_n,
   output logic [63:0] imem_addr,
   input  logic [31:0] imem_instr,
   input  logic        redirect_valid,
   input  logic [63:0] redirect_pc,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_instr,
   output logic [63:0] out_pc,
   output logic        fault,
   output logic [63:0] fault_pc
);

   localparam int unsigned CNT_W = $clog2(BUF_DEPTH + 1);

   fetch_state_t        state_q, state_d;
   logic [63:0]         pc_q, pc_d;
   logic                fault_d;
   logic [63:0]         fault_pc_d;
   logic                push, flush, deq, bad_pc_c;
   logic                buf_full, buf_empty;
   logic [CNT_W-1:0]    buf_count;
   fetch_entry_t        head, tail_entry;

   assign imem_addr  = pc_q;
   assign deq        = out_valid && out_ready;
   assign out_valid  = !buf_empty;
   assign out_instr  = head.instr;
   assign out_pc     = head.pc;
   assign tail_entry = '{pc: pc_q, instr: imem_instr};
   assign bad_pc_c   = (pc_q[1:0] != 2'b00) || ((pc_q + 64'd3) >= 64'(MEM_SIZE));

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= FETCH;
         pc_q     <= RESET_PC;
         fault    <= 1'b0;
         fault_pc <= 64'h0;
      end else begin
         state_q  <= state_d;
         pc_q     <= pc_d;
         fault    <= fault_d;
         fault_pc <= fault_pc_d;
      end
   end

   // Redirect wins over everything; otherwise fetch, stall on full, or trap.
   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      fault_d    = fault;
      fault_pc_d = fault_pc;
      push       = 1'b0;
      flush      = 1'b0;
      if (redirect_valid) begin
         flush   = 1'b1;
         pc_d    = redirect_pc;
         state_d = FETCH;
         fault_d = 1'b0;
      end else begin
         case (state_q)
            FETCH: begin
               if (bad_pc_c) begin
                  state_d    = FAULT;
                  fault_d    = 1'b1;
                  fault_pc_d = pc_q;
               end else if (!buf_full || deq) begin
                  push = 1'b1;
                  pc_d = pc_q + 64'd4;
               end
            end
            FAULT:   ;
            default: state_d = FETCH;
         endcase
      end
   end

   fetch_fifo #(
      .BUF_DEPTH (BUF_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .reset_n (reset_n),
      .push    (push),
      .pop     (deq),
      .flush   (flush),
      .wr_data (tail_entry),
      .rd_data (head),
      .count   (buf_count),
      .full    (buf_full),
      .empty   (buf_empty)
   );

   count_bound: assert property (@(posedge clk) disable iff (!reset_n)
      buf_count <= CNT_W'(BUF_DEPTH));

endmodule
